// File: rtl/trace_receiver.sv
// Trace stream receiver: valid/ready beat intake into a record FIFO with
// done/clear sequencing and protocol checking. Option: TRACE_RECEIVER_FILTER_EN.
module trace_receiver #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      TRACE_tdata,
  input  logic              TRACE_tvalid,
  output logic              TRACE_tready,
  input  logic              TRACE_tlast,
  output logic [31:0]       rec_pc,
  output logic [31:0]       rec_data,
  output logic [4:0]        rec_dest,
  output logic              rec_wen,
  output logic              rec_last,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CNT_W-1:0]  rec_count,
  output logic              done,
  input  logic              clear,
  output logic              proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        last;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } rec_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  rec_t          mem [DEPTH];
  rec_t          beat;
  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_nx;
  logic          accept;
  logic          keep;
  logic          push;
  logic          pop;
  logic          stall_q;
  logic [127:0]  tdata_q;
  logic          tlast_q;

  assign beat.last = TRACE_tlast;
  assign beat.wen  = TRACE_tdata[69];
  assign beat.dest = TRACE_tdata[68:64];
  assign beat.data = TRACE_tdata[63:32];
  assign beat.pc   = TRACE_tdata[31:0];

  assign accept = TRACE_tvalid & TRACE_tready;

`ifdef TRACE_RECEIVER_FILTER_EN
  // Non-writing beats are only counted; the tlast beat always lands.
  assign keep = beat.wen | beat.last;
`else
  assign keep = 1'b1;
`endif

  assign push      = accept & keep;
  assign rec_valid = (occ != '0);
  assign pop       = rec_valid & rec_ready;
  assign occ_nx    = occ + (AW+1)'(push) - (AW+1)'(pop);

  assign {rec_last, rec_wen, rec_dest, rec_data, rec_pc} = mem[rd_ptr];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept) state_nx = TRACE_tlast ? DONE : STREAM;
      STREAM: if (accept && TRACE_tlast) state_nx = DONE;
      DONE:   if (clear) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      TRACE_tready <= 1'b0;
      rec_count    <= '0;
      done         <= 1'b0;
      proto_err    <= 1'b0;
      stall_q      <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
    end else begin
      state        <= state_nx;
      done         <= (state_nx == DONE);
      occ          <= occ_nx;
      TRACE_tready <= (occ_nx < FULL) && (state_nx != DONE);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (state == DONE && clear)
        rec_count <= '0;
      else if (accept && rec_count != '1)
        rec_count <= rec_count + CNT_W'(1);
      // A stalled beat must be held unchanged until it is taken or dropped.
      stall_q <= TRACE_tvalid & ~TRACE_tready;
      tdata_q <= TRACE_tdata;
      tlast_q <= TRACE_tlast;
      if (stall_q && TRACE_tvalid &&
          (TRACE_tdata != tdata_q || TRACE_tlast != tlast_q))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: doc/trace_receiver.md
TRACE_RECEIVER -- requirements
Module: trace_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning record FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the accepted-record counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port TRACE_tdata  input  128  trace beat: [31:0] pc, [63:32] data, [68:64] dest, [69] wen, [127:70] ignored.
REQ-006 SHALL have port TRACE_tvalid  input  1  beat present.
REQ-007 SHALL have port TRACE_tready  output  1  receiver can accept a beat.
REQ-008 SHALL have port TRACE_tlast  input  1  final beat of the trace.
REQ-009 SHALL have ports rec_pc (32), rec_data (32), rec_dest (5), rec_wen (1), rec_last (1), all outputs, meaning the FIFO head record.
REQ-010 SHALL have port rec_valid  output  1  FIFO head is valid.
REQ-011 SHALL have port rec_ready  input  1  consumer pops the head when rec_valid is high.
REQ-012 SHALL have port rec_count  output  CNT_W  beats accepted since reset/clear.
REQ-013 SHALL have port done  output  1  tlast beat accepted.
REQ-014 SHALL have port clear  input  1  one-cycle pulse re-arming the receiver from DONE.
REQ-015 SHALL have port proto_err  output  1  sticky: tdata or tlast changed while tvalid high and tready low.

Function
REQ-016 Beat accepted exactly on cycles where TRACE_tvalid and TRACE_tready are both high; accepted beat written to the FIFO tail in the same edge.
REQ-017 TRACE_tready SHALL be a registered output: high next cycle iff the post-update occupancy is below DEPTH and the next state is not DONE.
REQ-018 Simultaneous push and pop with FIFO full SHALL be legal only when tready was high; occupancy unchanged; no record lost or duplicated.
REQ-019 rec_* outputs SHALL present the head with zero-cycle latency from FIFO storage; rec_valid high iff occupancy > 0; record popped on rec_valid and rec_ready.
REQ-020 Write/read pointers SHALL wrap modulo DEPTH; a record written at the last index is followed by index 0.
REQ-021 State machine: IDLE -> STREAM on first accepted beat without tlast; IDLE or STREAM -> DONE on accepted beat with tlast; DONE -> IDLE on clear; clear ignored in IDLE and STREAM.
REQ-022 done SHALL be high exactly while in DONE; tready low throughout DONE; FIFO continues draining in DONE.
REQ-023 rec_count SHALL increment by one per accepted beat and saturate at all-ones; reset to 0 by rst or by clear in DONE.
REQ-024 proto_err SHALL compare tdata/tlast against the previous cycle's value when the previous cycle had tvalid high and tready low and the current cycle has tvalid high; sticky until rst.
REQ-025 tvalid dropping without acceptance SHALL NOT set proto_err.

Reset
REQ-026 On rst: state IDLE, occupancy 0, pointers 0, rec_valid 0, TRACE_tready 0, rec_count 0, done 0, proto_err 0; TRACE_tready rises the first cycle after rst deasserts.
REQ-027 rst asserted mid-stream SHALL discard all FIFO contents; no beat accepted during a cycle with rst high.

Configuration
REQ-028 Macro TRACE_RECEIVER_FILTER_EN: when defined, accepted beats with wen=0 and tlast=0 SHALL be counted in rec_count but not written to the FIFO; when undefined, every accepted beat is written.
REQ-029 With TRACE_RECEIVER_FILTER_EN defined, an accepted wen=0 beat with tlast=1 SHALL still be written so rec_last is delivered.

Verification
REQ-030 Reset, then 3 beats pc=0x0,0x4,0x8 with rec_ready=1 -> rec records in order, rec_count=3, done=0, state STREAM.
REQ-031 rec_ready=0, DEPTH=16, continuous tvalid -> exactly 16 accepted, tready low one cycle after 16th; one pop -> tready high next cycle, 17th beat accepted.
REQ-032 Beat with tlast=1 at count 9 -> done=1, rec_count=10, tready=0; clear pulse -> done=0, rec_count=0, next beat accepted.
REQ-033 Hold tvalid with tready low, change tdata pc 0x10->0x14 -> proto_err=1 next cycle and remains 1 until rst.
REQ-034 rst asserted with 5 records queued -> rec_valid=0 next cycle, rec_count=0, pointers reused from index 0.
REQ-035 Filter build: beats wen=1,0,1,0(tlast) -> rec_count=4, FIFO delivers 3 records, last with rec_last=1; unfiltered build delivers 4.
